// File: rtl/sec_ded_pkg.sv
// Shared widths, codeword layout and status encoding for the SEC-DED correction stage.
package sec_ded_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned STAT_W = 2;

    localparam logic [ADDR_W-1:0] NO_FLIP = 4'hF;

    // Codeword positions (1-based) carrying data bits, index 0 = data LSB.
    localparam logic [ADDR_W-1:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12
    };

    typedef enum logic [STAT_W-1:0] {
        ST_CLEAN         = 2'd0,
        ST_CORRECTED     = 2'd1,
        ST_UNCORRECTABLE = 2'd2
    } status_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        status_e           status;
    } result_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            d[3'(i)] = code[4'(DATA_POS[3'(i)] - 4'd1)];
        end
        return d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sec_ded_correct.sv
// Final SEC-DED stage: applies the single-bit flip, classifies the word and keeps error statistics.
module sec_ded_correct
    import sec_ded_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  code_in,
    input  logic [ADDR_W-1:0]  address_flip,
    input  logic               dos_errors,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  code_out,
    output logic [DATA_W-1:0]  data_out,
    output status_e            status,
    output logic               scrub_req,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   single_cnt,
    output logic [CNT_W-1:0]   double_cnt,
    output logic               err_sticky
);

    logic    accept;
    result_t res;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign scrub_req = out_valid && (status == ST_CORRECTED);

    // Classification in decision order; position 0 means only the overall parity bit was hit.
    always_comb begin
        res.code   = code_in;
        res.status = ST_CLEAN;
        if (dos_errors) begin
            res.status = ST_UNCORRECTABLE;
        end else if ((address_flip == 4'd13) || (address_flip == 4'd14)) begin
            res.status = ST_UNCORRECTABLE;
        end else if (address_flip == 4'd0) begin
            res.status = ST_CORRECTED;
        end else if (address_flip <= 4'd12) begin
            res.status = ST_CORRECTED;
            res.code   = code_in ^ (CODE_W'(1) << (address_flip - 4'd1));
        end
    end

    // Output register: loads on accept, holds under backpressure, empties when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            code_out  <= '0;
            data_out  <= '0;
            status    <= ST_CLEAN;
        end else if (accept) begin
            out_valid <= 1'b1;
            code_out  <= res.code;
            data_out  <= extract_data(res.code);
            status    <= res.status;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (clr_stats) begin
            err_sticky <= 1'b0;
        end else if (accept && (res.status == ST_UNCORRECTABLE)) begin
            err_sticky <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_single_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && (res.status == ST_CORRECTED)),
        .clr   (clr_stats),
        .cnt   (single_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_double_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && (res.status == ST_UNCORRECTABLE)),
        .clr   (clr_stats),
        .cnt   (double_cnt)
    );

endmodule

// File: tb/tb_sec_ded_correct.sv
// Directed bench for sec_ded_correct with hand-computed expected results.
module tb_sec_ded_correct;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] code_in;
    logic [3:0]  address_flip;
    logic        dos_errors;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] code_out;
    logic [7:0]  data_out;
    logic [1:0]  status;
    logic        scrub_req;
    logic        clr_stats;
    logic [7:0]  single_cnt;
    logic [7:0]  double_cnt;
    logic        err_sticky;

    int errors = 0;
    int checks = 0;

    sec_ded_correct #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .code_in      (code_in),
        .address_flip (address_flip),
        .dos_errors   (dos_errors),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .code_out     (code_out),
        .data_out     (data_out),
        .status       (status),
        .scrub_req    (scrub_req),
        .clr_stats    (clr_stats),
        .single_cnt   (single_cnt),
        .double_cnt   (double_cnt),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle accept of a word; out_ready is left as the caller set it.
    task automatic send(input logic [11:0] code, input logic [3:0] flip, input logic dos);
        in_valid     = 1'b1;
        code_in      = code;
        address_flip = flip;
        dos_errors   = dos;
        tick();
        in_valid     = 1'b0;
    endtask

    logic [11:0] words [4];
    int          idx;
    int          rcv;
    logic        acc_now;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; code_in = '0; address_flip = 4'hF;
        dos_errors = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_code_out", 32'(code_out), 32'h000);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_status", 32'(status), 32'd0);
        check("rst_counts", {16'd0, single_cnt, double_cnt}, 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);

        // Single-bit correction at position 5.
        send(12'h000, 4'd5, 1'b0);
        check("flip5_code", 32'(code_out), 32'h010);
        check("flip5_data", 32'(data_out), 32'h02);
        check("flip5_status", 32'(status), 32'd1);
        check("flip5_scrub", 32'(scrub_req), 32'd1);
        check("flip5_single", 32'(single_cnt), 32'd1);
        check("flip5_valid", 32'(out_valid), 32'd1);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        send(12'hFFF, 4'hF, 1'b0);
        check("clean_code", 32'(code_out), 32'hFFF);
        check("clean_data", 32'(data_out), 32'hFF);
        check("clean_status", 32'(status), 32'd0);
        check("clean_scrub", 32'(scrub_req), 32'd0);
        check("clean_counts", {16'd0, single_cnt, double_cnt}, {16'd0, 8'd1, 8'd0});

        send(12'hA5C, 4'hF, 1'b1);
        check("dos_status", 32'(status), 32'd2);
        check("dos_code", 32'(code_out), 32'hA5C);
        send(12'h123, 4'd13, 1'b0);
        check("a13_status", 32'(status), 32'd2);
        check("a13_code", 32'(code_out), 32'h123);
        check("a13_data", 32'(data_out), 32'h14);
        check("a13_double", 32'(double_cnt), 32'd2);
        check("a13_sticky", 32'(err_sticky), 32'd1);

        send(12'h555, 4'd0, 1'b0);
        check("p0_code", 32'(code_out), 32'h555);
        check("p0_status", 32'(status), 32'd1);
        send(12'h000, 4'd12, 1'b0);
        check("a12_code", 32'(code_out), 32'h800);
        check("a12_data", 32'(data_out), 32'h80);
        send(12'hFFF, 4'd3, 1'b0);
        check("a3_code", 32'(code_out), 32'hFFB);
        check("a3_data", 32'(data_out), 32'hFE);
        send(12'h0F0, 4'd14, 1'b0);
        check("a14_status", 32'(status), 32'd2);
        check("a14_code", 32'(code_out), 32'h0F0);
        check("mix_counts", {16'd0, single_cnt, double_cnt}, {16'd0, 8'd4, 8'd3});

        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_counts", {16'd0, single_cnt, double_cnt}, 32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);

        // Backpressure: first word accepted, then the consumer stalls.
        words[0] = 12'h111; words[1] = 12'h222; words[2] = 12'h333; words[3] = 12'h444;
        address_flip = 4'hF; dos_errors = 1'b0;
        in_valid = 1'b1; code_in = words[0];
        tick();
        out_ready = 1'b0;
        code_in   = words[1];
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_code", 32'(code_out), 32'(words[0]));
            tick();
        end
        out_ready = 1'b1;
        #1;
        idx = 1;
        rcv = 0;
        for (int c = 0; c < 20 && rcv < 4; c++) begin
            if (out_valid) begin
                check("bp_order", 32'(code_out), 32'(words[rcv]));
                rcv++;
            end
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) idx++;
            if (idx < 4) code_in = words[idx];
            else in_valid = 1'b0;
            #1;
        end
        check("bp_received", 32'(rcv), 32'd4);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Saturation with 300 back-to-back corrected words.
        in_valid = 1'b1; code_in = 12'h000; address_flip = 4'd1;
        for (int n = 0; n < 300; n++) tick();
        in_valid = 1'b0;
        check("sat_single", 32'(single_cnt), 32'd255);
        check("sat_double", 32'(double_cnt), 32'd0);
        clr_stats = 1'b1;
        send(12'h000, 4'd1, 1'b0);
        clr_stats = 1'b0;
        check("clr_prio_single", 32'(single_cnt), 32'd0);
        check("clr_prio_valid", 32'(out_valid), 32'd1);
        check("clr_prio_code", 32'(code_out), 32'h001);

        // Reset while a word is stalled in the output register.
        send(12'h000, 4'd13, 1'b0);
        out_ready = 1'b0;
        send(12'h000, 4'd2, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_double", 32'(double_cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_counts", {16'd0, single_cnt, double_cnt}, 32'd0);
        check("mid_rst_sticky", 32'(err_sticky), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_status", 32'(status), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
